// File: rtl/ia_sparse_encoder_if.sv
// ia_sparse_encoder_if: dense channel stream in, packed IA bundle out to the PE.
// Rev 1.0
`default_nettype none

interface ia_sparse_encoder_if #(
   parameter int CHANNEL = 32,
   parameter int DATA_W  = 16,
   parameter int C_W     = 5,
   parameter int ROW     = 32,
   parameter int COL     = 32
);
   localparam int LEN_W = $clog2(CHANNEL) + 1;
   localparam int H_W   = $clog2(ROW) + 1;
   localparam int W_W   = $clog2(COL) + 1;

   logic                           i_valid;
   logic                           o_ready;
   logic signed [DATA_W-1:0]       i_data;
   logic                           i_last;
   logic [H_W-1:0]                 i_h;
   logic [W_W-1:0]                 i_w;
   logic                           o_start;
   logic                           i_finish;
   logic [CHANNEL-1:0][DATA_W-1:0] o_ia_data;
   logic [CHANNEL-1:0][C_W-1:0]    o_ia_c_idx;
   logic [LEN_W-1:0]               o_ia_len;
   logic [LEN_W-1:0]               o_ia_iters;
   logic [H_W-1:0]                 o_ia_h;
   logic [W_W-1:0]                 o_ia_w;
   logic                           o_skip;
   logic                           o_overflow;

   modport slave (
      input  i_valid, i_data, i_last, i_h, i_w, i_finish,
      output o_ready, o_start, o_ia_data, o_ia_c_idx, o_ia_len, o_ia_iters,
             o_ia_h, o_ia_w, o_skip, o_overflow
   );

   modport master (
      output i_valid, i_data, i_last, i_h, i_w, i_finish,
      input  o_ready, o_start, o_ia_data, o_ia_c_idx, o_ia_len, o_ia_iters,
             o_ia_h, o_ia_w, o_skip, o_overflow
   );
endinterface

`default_nettype wire

// File: rtl/ia_sparse_encoder.sv
// ia_sparse_encoder: packs nonzero channel activations of one pixel into the PE IA bundle.
// Rev 1.0
`default_nettype none

module ia_sparse_encoder #(
   parameter int CHANNEL = 32,
   parameter int DATA_W  = 16,
   parameter int C_W     = 5,
   parameter int ROW     = 32,
   parameter int COL     = 32
) (
   input  wire logic          i_clk,
   input  wire logic          i_rst,
   ia_sparse_encoder_if.slave bus
);
   localparam int LEN_W = $clog2(CHANNEL) + 1;
   localparam int H_W   = $clog2(ROW) + 1;
   localparam int W_W   = $clog2(COL) + 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_ISSUE   = 2'd2,
      S_WAIT    = 2'd3
   } state_t;

   state_t                         r_state;
   logic [CHANNEL-1:0][DATA_W-1:0] r_data;
   logic [CHANNEL-1:0][C_W-1:0]    r_idx;
   logic [LEN_W-1:0]               r_len;
   logic [LEN_W-1:0]               r_ch;
   logic [H_W-1:0]                 r_h;
   logic [W_W-1:0]                 r_w;
   logic                           r_ready;
   logic                           r_start;
   logic                           r_skip;
   logic                           r_ovf;

   logic             w_accept;
   logic             w_in_range;
   logic             w_wr;
   logic [LEN_W-1:0] w_len_next;

   assign w_accept   = bus.i_valid && r_ready;
   assign w_in_range = (r_ch < LEN_W'(CHANNEL));
   assign w_wr       = w_accept && w_in_range && (bus.i_data != '0);
   assign w_len_next = r_len + LEN_W'(w_wr);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_data  <= '0;
         r_idx   <= '0;
         r_len   <= '0;
         r_ch    <= '0;
         r_h     <= '0;
         r_w     <= '0;
         r_ready <= 1'b1;
         r_start <= 1'b0;
         r_skip  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_start <= 1'b0;
         r_skip  <= 1'b0;
         case (r_state)
            S_IDLE, S_COLLECT: begin
               if (w_accept) begin
                  if (r_state == S_IDLE) begin
                     r_h <= bus.i_h;
                     r_w <= bus.i_w;
                  end
                  if (w_wr) begin
                     r_data[r_len[C_W-1:0]] <= bus.i_data;
                     r_idx[r_len[C_W-1:0]]  <= r_ch[C_W-1:0];
                  end
                  r_len <= w_len_next;
                  // Counter stops at CHANNEL; every beat beyond it is dropped and flagged.
                  if (w_in_range) begin
                     r_ch <= r_ch + 1'b1;
                  end else begin
                     r_ovf <= 1'b1;
                  end
                  if (bus.i_last) begin
                     if (w_len_next != '0) begin
                        r_state <= S_ISSUE;
                        r_start <= 1'b1;
                        r_ready <= 1'b0;
                     end else begin
                        // All-zero pixel: nothing to hand the PE, slots are already zero.
                        r_state <= S_IDLE;
                        r_skip  <= 1'b1;
                        r_len   <= '0;
                        r_ch    <= '0;
                        r_h     <= '0;
                        r_w     <= '0;
                     end
                  end else begin
                     r_state <= S_COLLECT;
                  end
               end
            end
            S_ISSUE: begin
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (bus.i_finish) begin
                  r_state <= S_IDLE;
                  r_data  <= '0;
                  r_idx   <= '0;
                  r_len   <= '0;
                  r_ch    <= '0;
                  r_h     <= '0;
                  r_w     <= '0;
                  r_ready <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign bus.o_ready    = r_ready;
   assign bus.o_start    = r_start;
   assign bus.o_skip     = r_skip;
   assign bus.o_overflow = r_ovf;
   assign bus.o_ia_data  = r_data;
   assign bus.o_ia_c_idx = r_idx;
   assign bus.o_ia_len   = r_len;
   assign bus.o_ia_iters = {{(LEN_W-1){1'b0}}, (r_len != '0)};
   assign bus.o_ia_h     = r_h;
   assign bus.o_ia_w     = r_w;

endmodule

`default_nettype wire

// File: tb/tb_ia_sparse_encoder.sv
// tb_ia_sparse_encoder: directed test-plan pixels plus random pixels checked against a queue model.
// Rev 1.0
`default_nettype none

module tb_ia_sparse_encoder;
   localparam int CHANNEL = 32;
   localparam int DATA_W  = 16;
   localparam int C_W     = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   logic [DATA_W-1:0] exp_d[$];
   int                exp_i[$];
   int                exp_h;
   int                exp_w;
   bit                exp_ovf;

   always #5 clk = ~clk;

   ia_sparse_encoder_if #(.CHANNEL(CHANNEL), .DATA_W(DATA_W), .C_W(C_W), .ROW(32), .COL(32)) dif ();

   ia_sparse_encoder #(.CHANNEL(CHANNEL), .DATA_W(DATA_W), .C_W(C_W), .ROW(32), .COL(32)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (dif)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic model_clear();
      exp_d.delete();
      exp_i.delete();
      exp_h = 0;
      exp_w = 0;
   endtask

   task automatic check_bundle(input string tag);
      chk({tag, ".len"}, 32'(dif.o_ia_len), exp_d.size());
      chk({tag, ".iters"}, 32'(dif.o_ia_iters), (exp_d.size() > 0) ? 1 : 0);
      chk({tag, ".h"}, 32'(dif.o_ia_h), exp_h);
      chk({tag, ".w"}, 32'(dif.o_ia_w), exp_w);
      for (int k = 0; k < CHANNEL; k++) begin
         chk($sformatf("%s.data[%0d]", tag, k), 32'(dif.o_ia_data[k]),
             (k < exp_d.size()) ? 32'(exp_d[k]) : 32'd0);
         chk($sformatf("%s.c_idx[%0d]", tag, k), 32'(dif.o_ia_c_idx[k]),
             (k < exp_i.size()) ? exp_i[k] : 0);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      dif.i_valid  = 1'b0;
      dif.i_last   = 1'b0;
      dif.i_finish = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      model_clear();
      exp_ovf = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      chk({tag, ".ready"}, 32'(dif.o_ready), 1);
      chk({tag, ".start"}, 32'(dif.o_start), 0);
      chk({tag, ".skip"}, 32'(dif.o_skip), 0);
      chk({tag, ".ovf"}, 32'(dif.o_overflow), 32'(exp_ovf));
      check_bundle(tag);
   endtask

   // Present one beat and hold it until the encoder accepts it (bounded).
   task automatic send_beat(input int v, input bit last, input int h, input int w);
      int guard = 0;
      bit acc   = 1'b0;
      dif.i_valid = 1'b1;
      dif.i_data  = DATA_W'(v);
      dif.i_last  = last;
      dif.i_h     = 6'(h);
      dif.i_w     = 6'(w);
      while (!acc && guard < 100) begin
         acc = dif.o_ready;
         @(posedge clk); #1;
         guard++;
      end
      dif.i_valid = 1'b0;
      dif.i_last  = 1'b0;
      chk("beat_accepted", 32'(acc), 1);
   endtask

   task automatic send_pixel(input int vals[$], input int h, input int w, input bit gaps,
                             output bit issued);
      model_clear();
      exp_h = h;
      exp_w = w;
      for (int i = 0; i < vals.size(); i++) begin
         int v;
         v = vals[i];
         if (gaps && $urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
         send_beat(v, i == vals.size() - 1, (i == 0) ? h : int'($urandom_range(0, 63)),
                   (i == 0) ? w : int'($urandom_range(0, 63)));
         if (i >= CHANNEL) begin
            exp_ovf = 1'b1;
         end else if (v[DATA_W-1:0] != '0) begin
            exp_d.push_back(v[DATA_W-1:0]);
            exp_i.push_back(i);
         end
         chk("overflow_flag", 32'(dif.o_overflow), 32'(exp_ovf));
      end
      issued = (exp_d.size() > 0);
      if (issued) begin
         chk("start_pulse", 32'(dif.o_start), 1);
         chk("no_skip", 32'(dif.o_skip), 0);
         chk("ready_low_issue", 32'(dif.o_ready), 0);
         check_bundle("issue");
      end else begin
         exp_h = 0;
         exp_w = 0;
         chk("skip_pulse", 32'(dif.o_skip), 1);
         chk("no_start_skip", 32'(dif.o_start), 0);
         chk("ready_skip", 32'(dif.o_ready), 1);
         check_bundle("skip");
         @(posedge clk); #1;
         chk("skip_one_cycle", 32'(dif.o_skip), 0);
         chk("no_start_after_skip", 32'(dif.o_start), 0);
      end
   endtask

   // Keep the PE busy for `hold` cycles (optionally pushing beats), then finish.
   task automatic finish_pixel(input int hold, input bit push);
      for (int c = 0; c < hold; c++) begin
         dif.i_valid = push;
         dif.i_data  = DATA_W'($urandom_range(1, 100));
         @(posedge clk); #1;
         chk("start_once", 32'(dif.o_start), 0);
         chk("ready_low_wait", 32'(dif.o_ready), 0);
         chk("len_stable", 32'(dif.o_ia_len), exp_d.size());
         chk("data0_stable", 32'(dif.o_ia_data[0]), 32'(exp_d[0]));
      end
      dif.i_valid = 1'b0;
      check_bundle("wait_hold");
      dif.i_finish = 1'b1;
      @(posedge clk); #1;
      dif.i_finish = 1'b0;
      model_clear();
      check_idle("after_finish");
   endtask

   initial begin
      int pix[$];
      bit issued;
      dif.i_valid  = 1'b0;
      dif.i_data   = '0;
      dif.i_last   = 1'b0;
      dif.i_h      = '0;
      dif.i_w      = '0;
      dif.i_finish = 1'b0;
      exp_ovf      = 1'b0;
      model_clear();

      do_reset();
      check_idle("reset");

      pix = {0, 0, 2, 3, 0, 5, 6, 0};
      send_pixel(pix, 4, 4, 1'b0, issued);
      finish_pixel(20, 1'b1);

      pix.delete();
      for (int i = 0; i < 16; i++) pix.push_back(0);
      send_pixel(pix, 7, 9, 1'b0, issued);
      check_idle("after_skip");

      pix.delete();
      for (int i = 0; i < 34; i++) pix.push_back(1);
      send_pixel(pix, 3, 5, 1'b0, issued);
      finish_pixel(2, 1'b0);
      pix = {0, 4};
      send_pixel(pix, 1, 2, 1'b0, issued);
      finish_pixel(1, 1'b0);
      do_reset();
      check_idle("ovf_cleared");

      pix = {-1, 0, -7};
      send_pixel(pix, 10, 11, 1'b0, issued);
      finish_pixel(3, 1'b0);

      for (int i = 0; i < 5; i++) send_beat(i + 1, 1'b0, 8, 8);
      do_reset();
      check_idle("reset_mid_collect");
      pix = {9};
      send_pixel(pix, 2, 3, 1'b0, issued);
      finish_pixel(1, 1'b0);

      pix = {1, 2};
      send_pixel(pix, 5, 6, 1'b0, issued);
      @(posedge clk); #1;
      do_reset();
      check_idle("reset_in_wait");

      for (int p = 0; p < 25; p++) begin
         int n;
         n = $urandom_range(1, 40);
         pix.delete();
         for (int i = 0; i < n; i++)
            pix.push_back(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 65535)));
         send_pixel(pix, $urandom_range(0, 32), $urandom_range(0, 32), 1'b1, issued);
         if (issued) finish_pixel($urandom_range(1, 5), $urandom_range(0, 1));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/ia_sparse_encoder.md
Name: ia_sparse_encoder

Overview:
- Upstream feeder for the sparse-convolution PE.
- Accepts one pixel's dense input-activation channel vector as a valid/ready stream, one channel per beat.
- Packs the nonzero values with their channel indices into the PE's IA bundle (data, c_idx, len, iters, h, w).
- Pulses start to the PE, then holds the bundle stable until the PE reports finish.

Parameters:
CHANNEL, 32, max channels per pixel (matches IA_CHANNEL)
DATA_W, 16, activation data width (matches IA_DATA_BITWIDTH)
C_W, 5, channel index width (matches IA_C_BITWIDTH; must satisfy 2^C_W >= CHANNEL)
ROW, 32, max pixel row (IA_ROW)
COL, 32, max pixel column (IA_COL)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  synchronous reset, active-high
i_valid  in  1  input beat valid
o_ready  out  1  encoder can accept a beat
i_data  in  DATA_W signed  dense activation for the current channel
i_last  in  1  final channel beat of this pixel
i_h  in  clog2(ROW)+1  pixel row, sampled on first beat
i_w  in  clog2(COL)+1  pixel column, sampled on first beat
o_start  out  1  one-cycle start pulse to PE
i_finish  in  1  PE done with current bundle
o_ia_data  out  CHANNEL x DATA_W signed  packed nonzero values
o_ia_c_idx  out  CHANNEL x C_W  channel index of each packed value
o_ia_len  out  clog2(CHANNEL)+1  number of packed entries
o_ia_iters  out  clog2(CHANNEL)+1  1 if len>0, else 0
o_ia_h  out  clog2(ROW)+1  latched row
o_ia_w  out  clog2(COL)+1  latched column
o_skip  out  1  one-cycle pulse: all-zero pixel dropped
o_overflow  out  1  sticky: pixel had more than CHANNEL beats

Behaviour:
- Reset (i_rst=1 at a clock edge): state IDLE; every output 0 except o_ready=1. All bundle slots, len, ch counter, h/w and o_overflow are cleared. Reset overrides any state, including mid-COLLECT and WAIT. A partial pixel is discarded and no start is issued.
- A beat is accepted when i_valid && o_ready at a clock edge.
- o_ready=1 in IDLE and COLLECT only.
- States:
  - IDLE: on accept, latch i_h/i_w, treat the beat as channel 0, go to COLLECT. If i_last is set on that beat, go straight to end-of-pixel handling.
  - COLLECT: each accepted beat has channel index ch (counter, 0-based).
    - If i_data!=0 and ch<CHANNEL: write slot[len] = {i_data, ch[C_W-1:0]}, then len++.
    - If ch>=CHANNEL: discard the beat and set o_overflow (sticky until reset). The ch counter saturates at CHANNEL.
    - An accepted beat with i_last ends the pixel. If the resulting len>0, go to ISSUE; if len==0, pulse o_skip for one cycle, clear, and return to IDLE.
  - ISSUE: o_start=1 for exactly one cycle, then go to WAIT.
  - WAIT: bundle outputs held bit-stable. On i_finish=1, clear bundle, len, ch, h and w, then go to IDLE. o_ready returns to 1 the cycle after i_finish.
- i_finish is ignored outside WAIT. The bundle is never modified while in ISSUE or WAIT.
- Latency: last beat accepted at edge N → o_start high during cycle N+1. The bundle is valid from cycle N+1 through the cycle in which i_finish is sampled.
- Unused slots (index>=len) read 0.
- Values are packed in ascending channel order. o_ia_c_idx[k] is strictly increasing for k<len.
- Zero test is exact (i_data==0), applied to the signed value. Negative values are nonzero.
- Single buffer: throughput is one pixel per (beats + 1 + PE busy time). Backpressure is through o_ready only.
- o_overflow is asserted starting the cycle after the offending beat is accepted.

Test Plan:
- Pixel h=4,w=4 with 8 beats {0,0,2,3,0,5,6,0} (last on 8th) → o_start pulse 1 cycle after last beat. len=4, iters=1, data={2,3,5,6}, c_idx={2,3,5,6}, slots 4..31 =0.
- Hold i_finish low for 20 cycles after start → bundle stable, o_ready=0, further i_valid beats not accepted. Raise i_finish → next cycle o_ready=1, bundle cleared, len=0.
- All-zero pixel of 16 beats → no o_start; o_skip pulses once 1 cycle after the last beat; state back to IDLE, o_ready stays 1.
- 34 beats all =1 without last until beat 34 → len=32, c_idx=0..31, o_overflow=1 and stays set across the following pixel until i_rst.
- Negative values {-1,0,-7} with last on beat 3 → len=2, data={-1,-7}, c_idx={0,2}.
- Assert i_rst mid-COLLECT after 5 beats, then send a new pixel {9} with last → no stale entries; len=1, data[0]=9, c_idx[0]=0. Also assert i_rst during WAIT → all outputs 0, o_ready=1 next cycle.
